// File: rtl/demux_word_serializer.sv
// Word-to-lane serializer: takes a WIDTH_IN word over valid/ready and emits
// WIDTH_IN/WIDTH_OUT lanes with back-pressure, selectable order and idle-word skipping.
module demux_word_serializer #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_IN-1:0]  data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [WIDTH_OUT-1:0] data_out,
    output logic                 valid_out,
    output logic                 last_out,
    input  logic                 ready_out
);
    localparam int RATIO    = WIDTH_IN / WIDTH_OUT;
    localparam int CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH    = 1 << CW;
    localparam int FIRST_LO = MSB_FIRST ? (RATIO - 1) * WIDTH_OUT : 0;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                          state_q, state_d;
    logic [WIDTH_IN-1:0]             sh, sh_d;
    logic [CW-1:0]                   cnt, cnt_d, cnt_inc;
    logic [WIDTH_OUT-1:0]            dout_d;
    logic                            last_d;
    logic [DEPTH-1:0][WIDTH_OUT-1:0] sh_lane;
    logic                            accept, load, advance;

    // Lane k of the held word in transmit order; entries past RATIO pad the
    // power-of-two table so a cnt-based index never leaves its range.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_lane
            if (k < RATIO) begin : g_used
                localparam int LO = MSB_FIRST ? (RATIO - 1 - k) * WIDTH_OUT : k * WIDTH_OUT;
                assign sh_lane[k] = sh[LO +: WIDTH_OUT];
            end else begin : g_pad
                assign sh_lane[k] = '0;
            end
        end
    endgenerate

    assign valid_out = (state_q == SEND);
    assign ready_in  = !reset && (!valid_out || (ready_out && last_out));
    assign accept    = valid_in && ready_in;
    // A zero word under SKIP_ZERO still completes its handshake but loads nothing.
    assign load      = accept && (!SKIP_ZERO || (data_in != '0));
    assign advance   = valid_out && ready_out;
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh;
        cnt_d   = cnt;
        dout_d  = data_out;
        last_d  = last_out;
        if (load) begin
            state_d = SEND;
            sh_d    = data_in;
            cnt_d   = '0;
            dout_d  = data_in[FIRST_LO +: WIDTH_OUT];
            last_d  = (RATIO == 1);
        end else if (advance) begin
            if (last_out) begin
                state_d = IDLE;
                last_d  = 1'b0;
            end else begin
                cnt_d  = cnt_inc;
                dout_d = sh_lane[cnt_inc];
                last_d = (cnt_inc == CW'(RATIO - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            data_out <= '0;
            last_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh       <= sh_d;
            cnt      <= cnt_d;
            data_out <= dout_d;
            last_out <= last_d;
        end
    end
endmodule

// File: tb/tb_demux_word_serializer.sv
// Scoreboard bench for demux_word_serializer across four parameterisations:
// 0: 32/8 MSB-first skip-zero, 1: LSB-first, 2: no skip, 3: 64/16.
module tb_demux_word_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] din  [4];
    logic        vin  [4];
    logic        rout [4];
    logic        rin  [4];
    logic        vo   [4];
    logic        lo   [4];
    logic [7:0]  d0, d1, d2;
    logic [15:0] d3;
    logic [63:0] dout [4];
    logic [64:0] sb   [4][$];
    logic [64:0] mon_e;
    int vec  = 0;
    int errs = 0;

    assign dout[0] = {56'b0, d0};
    assign dout[1] = {56'b0, d1};
    assign dout[2] = {56'b0, d2};
    assign dout[3] = {48'b0, d3};

    demux_word_serializer #(.WIDTH_IN(32), .WIDTH_OUT(8), .MSB_FIRST(1'b1), .SKIP_ZERO(1'b1)) u_a (
        .clk(clk), .reset(rst), .data_in(din[0][31:0]), .valid_in(vin[0]), .ready_in(rin[0]),
        .data_out(d0), .valid_out(vo[0]), .last_out(lo[0]), .ready_out(rout[0]));
    demux_word_serializer #(.WIDTH_IN(32), .WIDTH_OUT(8), .MSB_FIRST(1'b0), .SKIP_ZERO(1'b1)) u_b (
        .clk(clk), .reset(rst), .data_in(din[1][31:0]), .valid_in(vin[1]), .ready_in(rin[1]),
        .data_out(d1), .valid_out(vo[1]), .last_out(lo[1]), .ready_out(rout[1]));
    demux_word_serializer #(.WIDTH_IN(32), .WIDTH_OUT(8), .MSB_FIRST(1'b1), .SKIP_ZERO(1'b0)) u_c (
        .clk(clk), .reset(rst), .data_in(din[2][31:0]), .valid_in(vin[2]), .ready_in(rin[2]),
        .data_out(d2), .valid_out(vo[2]), .last_out(lo[2]), .ready_out(rout[2]));
    demux_word_serializer #(.WIDTH_IN(64), .WIDTH_OUT(16), .MSB_FIRST(1'b1), .SKIP_ZERO(1'b1)) u_d (
        .clk(clk), .reset(rst), .data_in(din[3]), .valid_in(vin[3]), .ready_in(rin[3]),
        .data_out(d3), .valid_out(vo[3]), .last_out(lo[3]), .ready_out(rout[3]));

    // Every consumed lane is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (vo[i] && rout[i]) begin
                    vec++;
                    if (sb[i].size() == 0) begin
                        errs++;
                        $display("FAIL lane_extra inst%0d got data=%h last=%b, expected no lane", i, dout[i], lo[i]);
                    end else begin
                        mon_e = sb[i].pop_front();
                        if ({lo[i], dout[i]} !== mon_e) begin
                            errs++;
                            $display("FAIL lane inst%0d got last=%b data=%h, expected last=%b data=%h",
                                     i, lo[i], dout[i], mon_e[64], mon_e[63:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int i, input logic last, input logic [63:0] d);
        sb[i].push_back({last, d});
    endtask

    // Presents a word and returns just after the edge that accepted it.
    task automatic send(input int i, input logic [63:0] w);
        int n = 0;
        @(posedge clk); #1;
        din[i] = w;
        vin[i] = 1'b1;
        @(negedge clk);
        while (!rin[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (!rin[i]) begin
            errs++;
            $display("FAIL send_timeout inst%0d ready_in=%b, expected 1", i, rin[i]);
        end
        @(posedge clk); #1;
        vin[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n = 0;
        while ((sb[i].size() != 0 || vo[i]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (sb[i].size() != 0 || vo[i]) begin
            errs++;
            $display("FAIL drain inst%0d pending=%0d valid_out=%b, expected 0 and 0", i, sb[i].size(), vo[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vec++;
            if ({vo[i], lo[i], dout[i], rin[i]} !== 67'b0) begin
                errs++;
                $display("FAIL reset_state inst%0d got v=%b l=%b d=%h rdy=%b, expected all 0",
                         i, vo[i], lo[i], dout[i], rin[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (rin[0] !== 1'b1 || vo[0] !== 1'b0) begin
            errs++;
            $display("FAIL idle_ready got rdy=%b v=%b, expected rdy=1 v=0", rin[0], vo[0]);
        end
    endtask

    task automatic test_single();
        push(0, 0, 'hA1); push(0, 0, 'hB2); push(0, 0, 'hC3); push(0, 1, 'hD4);
        send(0, 'hA1B2C3D4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec++;
            if (vo[0] !== 1'b1) begin
                errs++;
                $display("FAIL single_valid beat%0d got %b, expected 1", k, vo[0]);
            end
        end
        @(negedge clk);
        vec++;
        if (vo[0] !== 1'b0 || lo[0] !== 1'b0) begin
            errs++;
            $display("FAIL single_end got v=%b l=%b, expected 0 0", vo[0], lo[0]);
        end
    endtask

    task automatic test_back_to_back();
        push(0, 0, 'h11); push(0, 0, 'h22); push(0, 0, 'h33); push(0, 1, 'h44);
        push(0, 0, 'h55); push(0, 0, 'h66); push(0, 0, 'h77); push(0, 1, 'h88);
        @(posedge clk); #1;
        din[0] = 'h11223344;
        vin[0] = 1'b1;
        @(posedge clk); #1;
        din[0] = 'h55667788;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec++;
            if (vo[0] !== 1'b1 || rin[0] !== ((k % 4) == 3)) begin
                errs++;
                $display("FAIL b2b beat%0d got v=%b rdy=%b, expected v=1 rdy=%b", k, vo[0], rin[0], (k % 4) == 3);
            end
            if (k == 3) begin
                @(posedge clk); #1;
                vin[0] = 1'b0;
            end
        end
        @(negedge clk);
        vec++;
        if (vo[0] !== 1'b0) begin
            errs++;
            $display("FAIL b2b_end got v=%b, expected 0", vo[0]);
        end
    endtask

    task automatic test_stall();
        push(1, 0, 'hD4); push(1, 0, 'hC3); push(1, 0, 'hB2); push(1, 1, 'hA1);
        send(1, 'hA1B2C3D4);
        @(negedge clk);
        @(posedge clk); #1;
        rout[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec++;
            if ({vo[1], lo[1], rin[1], dout[1]} !== {3'b100, 64'hC3}) begin
                errs++;
                $display("FAIL stall_hold cyc%0d got v=%b l=%b rdy=%b d=%h, expected v=1 l=0 rdy=0 d=c3",
                         k, vo[1], lo[1], rin[1], dout[1]);
            end
        end
        @(posedge clk); #1;
        rout[1] = 1'b1;
        drain(1);
    endtask

    task automatic test_skip_zero();
        send(0, 64'h0);
        @(negedge clk);
        vec++;
        if (vo[0] !== 1'b0) begin
            errs++;
            $display("FAIL skip_zero_beat got v=%b, expected 0", vo[0]);
        end
        push(0, 0, 'h01); push(0, 0, 'h02); push(0, 0, 'h03); push(0, 1, 'h04);
        send(0, 'h01020304);
        drain(0);
        push(2, 0, 'h00); push(2, 0, 'h00); push(2, 0, 'h00); push(2, 1, 'h00);
        push(2, 0, 'h01); push(2, 0, 'h02); push(2, 0, 'h03); push(2, 1, 'h04);
        send(2, 64'h0);
        send(2, 'h01020304);
        drain(2);
    endtask

    task automatic test_reset_mid();
        push(0, 0, 'hA1);
        send(0, 'hA1B2C3D4);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (rin[0] !== 1'b0) begin
            errs++;
            $display("FAIL reset_ready got %b, expected 0", rin[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vec++;
            if ({vo[0], lo[0], dout[0]} !== 66'b0) begin
                errs++;
                $display("FAIL reset_mid cyc%0d got v=%b l=%b d=%h, expected 0 0 0", k, vo[0], lo[0], dout[0]);
            end
        end
        vec++;
        if (sb[0].size() != 0) begin
            errs++;
            $display("FAIL reset_pending got %0d lanes outstanding, expected 0", sb[0].size());
        end
        push(0, 0, 'hDE); push(0, 0, 'hAD); push(0, 0, 'hBE); push(0, 1, 'hEF);
        send(0, 'hDEADBEEF);
        drain(0);
    endtask

    task automatic test_wide();
        push(3, 0, 'h0123); push(3, 0, 'h4567); push(3, 0, 'h89AB); push(3, 1, 'hCDEF);
        send(3, 64'h0123456789ABCDEF);
        drain(3);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[i]  = '0;
            vin[i]  = 1'b0;
            rout[i] = 1'b1;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_skip_zero();
        test_reset_mid();
        test_wide();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
